// File: rtl/ddr_cmd_responder_if.sv
// Command bus from the controller plus the responder's beat strobes and status.
// The command bus is sampled on every posedge and has no backpressure; rd_valid/wr_valid are one-cycle-per-beat strobes with no ready.
interface ddr_cmd_responder_if;
    logic        cke;
    logic        ras;
    logic        cas;
    logic        we;
    logic [1:0]  ba;
    logic [12:0] addr;

    logic        rd_valid;
    logic        wr_valid;
    logic [1:0]  burst_bank;
    logic [12:0] burst_row;
    logic [9:0]  burst_col;
    logic        burst_last;
    logic [3:0]  bank_open;
    logic        err;
    logic [2:0]  err_code;
    logic [1:0]  burst_state;

    modport master (
        output cke, ras, cas, we, ba, addr,
        input  rd_valid, wr_valid, burst_bank, burst_row, burst_col, burst_last,
        input  bank_open, err, err_code, burst_state
    );

    modport slave (
        input  cke, ras, cas, we, ba, addr,
        output rd_valid, wr_valid, burst_bank, burst_row, burst_col, burst_last,
        output bank_open, err, err_code, burst_state
    );
endinterface

// File: rtl/ddr_cmd_responder.sv
// Memory-side DDR command decoder: bank/row tracking, tRCD/tRP and mode checks,
// and read/write burst beat generation with sequential column wrap.
module ddr_cmd_responder #(
    parameter int TRCD   = 2,
    parameter int TRP    = 2,
    parameter int CL_RST = 2,
    parameter int BL_RST = 4
) (
    input logic clk,
    input logic rst,
    ddr_cmd_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;
    typedef struct packed {
        logic        valid;
        logic [3:0]  bl;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
    } rd_entry_t;

    localparam int CW = 4;
    localparam logic [CW-1:0] TRCD_LD = CW'(TRCD - 1);
    localparam logic [CW-1:0] TRP_LD  = CW'(TRP - 1);

    logic [3:0]    bank_open_q;
    logic [12:0]   row_q  [4];
    logic [CW-1:0] trcd_q [4];
    logic [CW-1:0] trp_q  [4];
    logic [2:0]    cl_q;
    logic [3:0]    bl_q;
    logic          err_q;
    logic [2:0]    err_code_q;
    rd_entry_t     dl_q [2];

    logic [1:0] sel;
    logic       is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic       rd_ok, wr_ok, act_ok, lmr_ok, mode_legal;
    logic [2:0] err_d;
    logic [3:0] close_v;
    rd_entry_t  rd_new;

    assign sel = bus.ba;
    assign mode_legal = (bus.addr[6:4] == 3'd2 || bus.addr[6:4] == 3'd3) &&
                        (bus.addr[2:0] inside {3'd1, 3'd2, 3'd3});

    always_comb begin
        is_act = 1'b0; is_rd = 1'b0; is_wr = 1'b0;
        is_pre = 1'b0; is_ref = 1'b0; is_lmr = 1'b0;
        if (bus.cke) begin
            unique case ({bus.ras, bus.cas, bus.we})
                3'b011:  is_act = 1'b1;
                3'b101:  is_rd  = 1'b1;
                3'b100:  is_wr  = 1'b1;
                3'b010:  is_pre = 1'b1;
                3'b001:  is_ref = 1'b1;
                3'b000:  is_lmr = 1'b1;
                default: ;
            endcase
        end
    end

    // An erroring command is dropped entirely; only the *_ok strobes change state.
    always_comb begin
        err_d = 3'd0; rd_ok = 1'b0; wr_ok = 1'b0; act_ok = 1'b0; lmr_ok = 1'b0;
        if (is_rd || is_wr) begin
            if (!bank_open_q[sel])      err_d = 3'd1;
            else if (trcd_q[sel] != '0) err_d = 3'd2;
            else begin
                rd_ok = is_rd;
                wr_ok = is_wr;
            end
        end else if (is_act) begin
            if (bank_open_q[sel])      err_d = 3'd3;
            else if (trp_q[sel] != '0) err_d = 3'd4;
            else                       act_ok = 1'b1;
        end else if (is_ref) begin
            if (|bank_open_q) err_d = 3'd5;
        end else if (is_lmr && sel == 2'd0) begin
            if (|bank_open_q)     err_d = 3'd5;
            else if (!mode_legal) err_d = 3'd6;
            else                  lmr_ok = 1'b1;
        end
    end

    always_comb begin
        close_v = '0;
        for (int i = 0; i < 4; i++) begin
            close_v[i] = bank_open_q[i] &&
                ((is_pre && (bus.addr[10] || sel == 2'(i))) ||
                 ((rd_ok || wr_ok) && bus.addr[10] && sel == 2'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_q <= '0;
            for (int i = 0; i < 4; i++) begin
                row_q[i]  <= '0;
                trcd_q[i] <= '0;
                trp_q[i]  <= '0;
            end
            cl_q       <= 3'(CL_RST);
            bl_q       <= 4'(BL_RST);
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (trcd_q[i] != '0) trcd_q[i] <= trcd_q[i] - 1'b1;
                if (trp_q[i] != '0)  trp_q[i]  <= trp_q[i] - 1'b1;
                if (act_ok && sel == 2'(i)) begin
                    bank_open_q[i] <= 1'b1;
                    row_q[i]       <= bus.addr;
                    trcd_q[i]      <= TRCD_LD;
                end
                if (close_v[i]) begin
                    bank_open_q[i] <= 1'b0;
                    trp_q[i]       <= TRP_LD;
                end
            end
            if (lmr_ok) begin
                cl_q <= bus.addr[6:4];
                unique case (bus.addr[1:0])
                    2'd1:    bl_q <= 4'd2;
                    2'd2:    bl_q <= 4'd4;
                    default: bl_q <= 4'd8;
                endcase
            end
            err_q      <= (err_d != 3'd0);
            err_code_q <= err_d;
        end
    end

    // Read delay line: entry 0 emerges next edge; CL=3 reads enter one slot further back.
    always_comb rd_new = '{valid: 1'b1, bl: bl_q, bank: sel, row: row_q[sel], col: bus.addr[9:0]};

    always_ff @(posedge clk) begin
        if (rst || wr_ok) begin
            dl_q[0] <= '0;
            dl_q[1] <= '0;
        end else begin
            dl_q[0] <= dl_q[1];
            dl_q[1] <= '0;
            if (rd_ok) begin
                if (cl_q == 3'd3) dl_q[1] <= rd_new;
                else              dl_q[0] <= rd_new;
            end
        end
    end

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [3:0]  bbl_q, bbl_d;
    logic [1:0]  bbank_q, bbank_d;
    logic [12:0] brow_q, brow_d;
    logic [9:0]  bcol_q, bcol_d;
    logic        last_beat, busy;
    logic [9:0]  mask, col_sum, col_wrap;

    assign last_beat = (beat_q == (bbl_q[3:1] - 3'd1));
    assign busy      = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            bbl_q   <= '0;
            bbank_q <= '0;
            brow_q  <= '0;
            bcol_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            bbl_q   <= bbl_d;
            bbank_q <= bbank_d;
            brow_q  <= brow_d;
            bcol_q  <= bcol_d;
        end
    end

    // A new write outranks a read leaving the delay line, since it flushes that line.
    always_comb begin
        state_d = state_q; beat_d = beat_q; bbl_d = bbl_q;
        bbank_d = bbank_q; brow_d = brow_q; bcol_d = bcol_q;
        if (wr_ok) begin
            state_d = S_WR; beat_d = '0; bbl_d = bl_q;
            bbank_d = sel; brow_d = row_q[sel]; bcol_d = bus.addr[9:0];
        end else if (dl_q[0].valid) begin
            state_d = S_RD; beat_d = '0; bbl_d = dl_q[0].bl;
            bbank_d = dl_q[0].bank; brow_d = dl_q[0].row; bcol_d = dl_q[0].col;
        end else if (rd_ok && state_q == S_WR) begin
            state_d = S_IDLE;
        end else if (busy) begin
            if (last_beat) state_d = S_IDLE;
            else           beat_d  = beat_q + 3'd1;
        end
    end

    assign mask     = {6'd0, bbl_q} - 10'd1;
    assign col_sum  = bcol_q + {6'd0, beat_q, 1'b0};
    assign col_wrap = (bcol_q & ~mask) | (col_sum & mask);

    assign bus.rd_valid    = (state_q == S_RD);
    assign bus.wr_valid    = (state_q == S_WR);
    assign bus.burst_bank  = busy ? bbank_q : 2'd0;
    assign bus.burst_row   = busy ? brow_q : 13'd0;
    assign bus.burst_col   = busy ? {col_wrap[9:1], 1'b0} : 10'd0;
    assign bus.burst_last  = busy && last_beat;
    assign bus.bank_open   = bank_open_q;
    assign bus.err         = err_q;
    assign bus.err_code    = err_code_q;
    assign bus.burst_state = state_q;
endmodule

// File: tb/tb_ddr_cmd_responder.sv
// Directed and random command traffic checked cycle by cycle against a
// timeline model of expected beats, bank state and error pulses.
module tb_ddr_cmd_responder;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int MAXC = 2048;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000, C_RSV = 3'b110;

    logic clk;
    logic rst;
    ddr_cmd_responder_if bus();

    ddr_cmd_responder #(.TRCD(TRCD), .TRP(TRP), .CL_RST(2), .BL_RST(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int t = 0;

    bit m_open [4];
    int m_row [4];
    int m_tact [4];
    int m_tclose [4];
    int m_cl, m_bl;
    int exp_open_n, exp_err_n, exp_code_n;
    int e_kind [MAXC];
    int e_bank [MAXC];
    int e_row [MAXC];
    int e_col [MAXC];
    int e_last [MAXC];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 0; m_row[b] = 0; m_tact[b] = -1000; m_tclose[b] = -1000;
        end
        m_cl = 2; m_bl = 4;
    endtask

    task automatic clear_from(input int s, input bit only_wr);
        for (int i = s; i < MAXC; i++) begin
            if (!only_wr || e_kind[i] == 2) begin
                e_kind[i] = 0; e_bank[i] = 0; e_row[i] = 0; e_col[i] = 0; e_last[i] = 0;
            end
        end
    endtask

    // Beat i covers col+2i, wrapping inside the BL-aligned block.
    task automatic schedule(input int kind, input int s, input int bank, input int row,
                            input int col, input int bl);
        int base, idx;
        base = col - (col % bl);
        for (int i = 0; i < bl / 2; i++) begin
            idx = s + i;
            if (idx < MAXC) begin
                e_kind[idx] = kind;
                e_bank[idx] = bank;
                e_row[idx]  = row;
                e_col[idx]  = (base + ((col % bl) + 2 * i) % bl) & 32'hFFFF_FFFE;
                e_last[idx] = (i == bl / 2 - 1) ? 1 : 0;
            end
        end
    endtask

    task automatic model_step(input bit r, input bit ck, input logic [2:0] cmd,
                              input logic [1:0] ba, input logic [12:0] addr);
        int code, b, col, clf, blf;
        bit any_open;
        code = 0;
        b = int'(ba);
        any_open = m_open[0] || m_open[1] || m_open[2] || m_open[3];
        if (r) begin
            model_reset();
            clear_from(t + 1, 0);
        end else if (ck) begin
            case (cmd)
                C_ACT: begin
                    if (m_open[b])                 code = 3;
                    else if (t < m_tclose[b] + TRP) code = 4;
                    else begin
                        m_open[b] = 1; m_row[b] = int'(addr); m_tact[b] = t;
                    end
                end
                C_RD, C_WR: begin
                    if (!m_open[b])               code = 1;
                    else if (t < m_tact[b] + TRCD) code = 2;
                    else begin
                        col = int'(addr[9:0]);
                        if (cmd == C_RD) begin
                            clear_from(t + 1, 1);
                            clear_from(t + m_cl, 0);
                            schedule(1, t + m_cl, b, m_row[b], col, m_bl);
                        end else begin
                            clear_from(t + 1, 0);
                            schedule(2, t + 1, b, m_row[b], col, m_bl);
                        end
                        if (addr[10]) begin
                            m_open[b] = 0; m_tclose[b] = t;
                        end
                    end
                end
                C_PRE: begin
                    for (int k = 0; k < 4; k++) begin
                        if ((addr[10] || k == b) && m_open[k]) begin
                            m_open[k] = 0; m_tclose[k] = t;
                        end
                    end
                end
                C_REF: if (any_open) code = 5;
                C_LMR: begin
                    if (b == 0) begin
                        clf = int'(addr[6:4]);
                        blf = int'(addr[2:0]);
                        if (any_open) code = 5;
                        else if ((clf == 2 || clf == 3) && blf >= 1 && blf <= 3) begin
                            m_cl = clf; m_bl = 1 << blf;
                        end else code = 6;
                    end
                end
                default: ;
            endcase
        end
        exp_err_n  = (code != 0) ? 1 : 0;
        exp_code_n = code;
        exp_open_n = 0;
        for (int k = 0; k < 4; k++) if (m_open[k]) exp_open_n += (1 << k);
    endtask

    function automatic logic [31:0] exp_burst(input int i);
        if (e_kind[i] == 0) return 32'd0;
        return {4'd0, e_kind[i] == 1, e_kind[i] == 2, 2'(e_bank[i]), 13'(e_row[i]),
                10'(e_col[i]), e_last[i] != 0};
    endfunction

    function automatic logic [31:0] obs_burst();
        return {4'd0, bus.rd_valid, bus.wr_valid, bus.burst_bank, bus.burst_row,
                bus.burst_col, bus.burst_last};
    endfunction

    function automatic logic [31:0] obs_status();
        return {24'd0, bus.bank_open, bus.err, bus.err_code};
    endfunction

    task automatic step(input bit r, input bit ck, input logic [2:0] cmd,
                        input logic [1:0] ba, input logic [12:0] addr);
        rst = r;
        bus.cke = ck;
        {bus.ras, bus.cas, bus.we} = cmd;
        bus.ba = ba;
        bus.addr = addr;
        model_step(r, ck, cmd, ba, addr);
        @(posedge clk);
        #1;
        t++;
        check("burst", obs_burst(), exp_burst(t));
        check("status", obs_status(), {24'd0, 4'(exp_open_n), exp_err_n != 0, 3'(exp_code_n)});
    endtask

    task automatic nop();
        step(1'b0, 1'b1, C_NOP, 2'd0, 13'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, C_NOP, 2'd0, 13'd0);
        step(1'b1, 1'b1, C_NOP, 2'd0, 13'd0);
    endtask

    int p, cl_v, bl_v;
    logic [2:0] c;
    logic [12:0] a;
    logic [1:0] bk;
    bit ck, r;

    initial begin
        rst = 1'b1;
        bus.cke = 1'b1; bus.ras = 1'b1; bus.cas = 1'b1; bus.we = 1'b1;
        bus.ba = 2'd0; bus.addr = 13'd0;

        // Read with CL=2, BL=4.
        do_reset();
        check("reset outputs", {obs_status(), obs_burst()} != 0, 32'd0);
        step(0, 1, C_ACT, 2'd1, 13'h155);
        nop();
        step(0, 1, C_RD, 2'd1, 13'h00C);
        check("tp1 no beat at T+1", bus.rd_valid, 32'd0);
        nop();
        check("tp1 beat0", {bus.rd_valid, bus.burst_bank, bus.burst_row, bus.burst_col, bus.burst_last},
              {1'b1, 2'd1, 13'h155, 10'h00C, 1'b0});
        nop();
        check("tp1 beat1", {bus.rd_valid, bus.burst_col, bus.burst_last, bus.bank_open},
              {1'b1, 10'h00E, 1'b1, 4'b0010});
        nop();
        check("tp1 burst done", bus.rd_valid, 32'd0);

        // READ before tRCD.
        do_reset();
        step(0, 1, C_ACT, 2'd1, 13'h155);
        step(0, 1, C_RD, 2'd1, 13'h00C);
        check("tp2 trcd error", {bus.err, bus.err_code}, {1'b1, 3'd2});
        nop(); nop(); nop();
        check("tp2 no read", bus.rd_valid, 32'd0);

        // Mode CL=3/BL=8 then wrapping write.
        do_reset();
        step(0, 1, C_LMR, 2'd0, 13'h033);
        step(0, 1, C_ACT, 2'd2, 13'h0AA);
        nop();
        step(0, 1, C_WR, 2'd2, 13'h006);
        check("tp3 wbeat0", {bus.wr_valid, bus.burst_col, bus.burst_last}, {1'b1, 10'h006, 1'b0});
        nop();
        check("tp3 wbeat1", {bus.wr_valid, bus.burst_col, bus.burst_last}, {1'b1, 10'h000, 1'b0});
        nop();
        check("tp3 wbeat2", {bus.wr_valid, bus.burst_col, bus.burst_last}, {1'b1, 10'h002, 1'b0});
        nop();
        check("tp3 wbeat3", {bus.wr_valid, bus.burst_col, bus.burst_last}, {1'b1, 10'h004, 1'b1});
        nop();
        check("tp3 write done", bus.wr_valid, 32'd0);

        // Illegal CL leaves mode at reset value.
        do_reset();
        step(0, 1, C_LMR, 2'd0, 13'h052);
        check("tp4 mode error", {bus.err, bus.err_code}, {1'b1, 3'd6});
        step(0, 1, C_ACT, 2'd0, 13'h001);
        nop();
        step(0, 1, C_RD, 2'd0, 13'h010);
        check("tp4 no beat at T+1", bus.rd_valid, 32'd0);
        nop();
        check("tp4 beat at T+2", {bus.rd_valid, bus.burst_col}, {1'b1, 10'h010});

        // Auto-precharge then tRP.
        do_reset();
        step(0, 1, C_ACT, 2'd3, 13'h0F0);
        nop();
        step(0, 1, C_RD, 2'd3, 13'h404);
        check("tp5 bank closed", bus.bank_open, 32'd0);
        step(0, 1, C_ACT, 2'd3, 13'h0F1);
        check("tp5 trp error", {bus.err, bus.err_code}, {1'b1, 3'd4});
        step(0, 1, C_ACT, 2'd3, 13'h0F1);
        check("tp5 active ok", {bus.err, bus.bank_open}, {1'b0, 4'b1000});

        // Write interrupts read, then reset mid-burst.
        do_reset();
        step(0, 1, C_ACT, 2'd0, 13'h033);
        nop();
        step(0, 1, C_RD, 2'd0, 13'h000);
        nop();
        check("tp6 read beat0", {bus.rd_valid, bus.burst_last}, {1'b1, 1'b0});
        step(0, 1, C_WR, 2'd0, 13'h020);
        check("tp6 write preempts", {bus.rd_valid, bus.wr_valid, bus.burst_col, bus.burst_last},
              {1'b0, 1'b1, 10'h020, 1'b0});
        step(0, 1, C_WR, 2'd0, 13'h040);
        check("tp6 second write", {bus.wr_valid, bus.burst_col}, {1'b1, 10'h040});
        step(1, 1, C_NOP, 2'd0, 13'd0);
        check("tp6 reset mid-burst", {obs_status(), obs_burst()} != 0, 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 900; n++) begin
            p  = $urandom_range(99);
            a  = 13'($urandom);
            bk = 2'($urandom_range(3));
            ck = ($urandom_range(19) != 0);
            r  = ($urandom_range(199) == 0);
            if (p < 20)      c = C_NOP;
            else if (p < 45) c = C_ACT;
            else if (p < 63) c = C_RD;
            else if (p < 77) c = C_WR;
            else if (p < 89) c = C_PRE;
            else if (p < 92) c = C_REF;
            else if (p < 97) c = C_LMR;
            else             c = C_RSV;
            if (c == C_RD || c == C_WR) a[10] = ($urandom_range(3) == 0);
            if (c == C_PRE) a[10] = ($urandom_range(4) == 0);
            if (c == C_LMR) begin
                if ($urandom_range(3) != 0) bk = 2'd0;
                cl_v = $urandom_range(4, 1);
                bl_v = $urandom_range(4, 0);
                a = 13'((cl_v << 4) | bl_v);
            end
            step(r, ck, c, bk, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
